fpu_sequencer: RTL and testbench
================================

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 Parameter ADD_LAT, default 2: cycles from operand launch to add/sub result capture (range 1..15).
REQ-002 Parameter MUL_LAT, default 2: cycles from operand launch to multiply result capture (range 1..15).
REQ-003 Parameter DIV_TIMEOUT, default 64: maximum cycles to wait for divider finish (range 2..255).
REQ-004 The block SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock shared with the FPU.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_funct  input  2  0 add, 1 sub, 2 div, 3 mul.
REQ-010 req_a, req_b  input  32 each  IEEE-754 single operands.
REQ-011 fpu_funct  output  2  held operation select to the FPU.
REQ-012 fpu_a, fpu_b  output  32 each  held operands to the FPU.
REQ-013 fpu_result  input  32  FPU result bus.
REQ-014 fpu_div_fin  input  1  divider finish flag.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer accepts result.
REQ-017 rsp_result  output  32  captured result.
REQ-018 rsp_funct  output  2  operation that produced rsp_result.
REQ-019 rsp_timeout  output  1  divide timed out; rsp_result is the qNaN constant.

Function
REQ-020 FSM states: IDLE, EXEC, RESP; req_ready SHALL be 1 only in IDLE, rsp_valid SHALL be 1 only in RESP.
REQ-021 IDLE: on req_valid&&req_ready at a rising edge, the sequencer SHALL register req_funct/req_a/req_b onto fpu_funct/fpu_a/fpu_b, clear the wait counter and enter EXEC.
REQ-022 fpu_funct, fpu_a and fpu_b SHALL remain stable from acceptance until the next acceptance.
REQ-023 EXEC, funct 0/1: the counter SHALL increment each cycle; when it reaches ADD_LAT the sequencer SHALL capture fpu_result into rsp_result and enter RESP.
REQ-024 EXEC, funct 3: same as REQ-023 using MUL_LAT.
REQ-025 EXEC, funct 2: fpu_div_fin SHALL be ignored in the first EXEC cycle; from the second cycle on, fpu_div_fin=1 at a rising edge SHALL capture fpu_result with rsp_timeout=0 and enter RESP.
REQ-026 EXEC, funct 2: if the counter reaches DIV_TIMEOUT without a qualifying finish, rsp_result SHALL be 32'h7FC00000, rsp_timeout=1, next state RESP.
REQ-027 If finish and timeout occur in the same cycle, finish SHALL win.
REQ-028 RESP: outputs SHALL hold until rsp_ready=1 at a rising edge, then return to IDLE; no new request SHALL be accepted in that same cycle.
REQ-029 Minimum request-to-request spacing: latency + 2 cycles; throughput is one operation in flight.
REQ-030 The counter SHALL be 8 bits and SHALL saturate, never wrap.

Reset
REQ-031 rst_n low SHALL immediately force IDLE: req_ready=1 after release, rsp_valid=0, rsp_result=0, rsp_funct=0, rsp_timeout=0, fpu_funct=0, fpu_a=0, fpu_b=0, counter=0.
REQ-032 Reset during EXEC or RESP SHALL discard the in-flight operation with no response produced.

Structure
REQ-033 Shared package fpu_pkg SHALL hold the funct encoding enum (FPU_ADD, FPU_SUB, FPU_DIV, FPU_MUL), the state enum, and the constant FPU_QNAN = 32'h7FC00000.
REQ-034 The block SHALL be a single flat module with no sub-modules; the FPU is instantiated beside it at the next level up.

Verification
REQ-035 Add: a=32'h3F800000, b=32'h40000000, funct 0, FPU model returns 32'h40400000 -> rsp_valid asserted exactly ADD_LAT+1 cycles after acceptance, rsp_result=32'h40400000, rsp_funct=0.
REQ-036 Divide: a=32'h40C00000, b=32'h40000000, model raises fin on cycle 5 -> rsp_result=32'h40400000, rsp_timeout=0; fin held high during the first EXEC cycle is ignored.
REQ-037 Divide timeout: fin never asserted, DIV_TIMEOUT=64 -> rsp_result=32'h7FC00000, rsp_timeout=1 after 64 EXEC cycles.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles with req_valid=1 -> rsp outputs stable, req_ready=0 throughout, exactly one response after rsp_ready=1.
REQ-039 Reset mid-EXEC of a multiply -> all outputs at reset values, no rsp_valid pulse, next request completes normally.
REQ-040 Fin and timeout in the same cycle -> captured fpu_result returned with rsp_timeout=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU sequencer: operation encoding, FSM states,
// the quiet-NaN returned on divide timeout and a saturating counter helper.
package fpu_pkg;

  typedef enum logic [1:0] {
    FPU_ADD = 2'd0,
    FPU_SUB = 2'd1,
    FPU_DIV = 2'd2,
    FPU_MUL = 2'd3
  } fpu_funct_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// One-at-a-time request sequencer for a multi-cycle FPU: holds operands on the
// FPU inputs, waits a fixed latency (or divider finish / timeout), returns result.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int ADD_LAT     = 2,
  parameter int MUL_LAT     = 2,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  fpu_funct,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  input  logic [31:0] fpu_result,
  input  logic        fpu_div_fin,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [1:0]  rsp_funct,
  output logic        rsp_timeout
);

  localparam logic [7:0] ADD_LIM = 8'(ADD_LAT);
  localparam logic [7:0] MUL_LIM = 8'(MUL_LAT);
  localparam logic [7:0] DIV_LIM = 8'(DIV_TIMEOUT);

  seq_state_e state;
  logic [7:0] cnt;
  logic [7:0] lat_lim;
  logic       fixed_done;
  logic       div_done;
  logic       div_expired;

  always_comb begin
    lat_lim = (fpu_funct == FPU_MUL) ? MUL_LIM : ADD_LIM;
  end

  // A finish flag left over from the previous divide is masked in the first EXEC cycle.
  assign fixed_done  = (cnt >= lat_lim);
  assign div_done    = (cnt != 8'd0) && fpu_div_fin;
  assign div_expired = (cnt >= DIV_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      req_ready   <= 1'b1;
      fpu_funct   <= 2'd0;
      fpu_a       <= 32'd0;
      fpu_b       <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 32'd0;
      rsp_funct   <= 2'd0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            fpu_funct <= req_funct;
            fpu_a     <= req_a;
            fpu_b     <= req_b;
            cnt       <= 8'd0;
            req_ready <= 1'b0;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (fpu_funct == FPU_DIV) begin
            // Finish beats timeout when both land on the same edge.
            if (div_done) begin
              rsp_result  <= fpu_result;
              rsp_timeout <= 1'b0;
              rsp_funct   <= fpu_funct;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else if (div_expired) begin
              rsp_result  <= FPU_QNAN;
              rsp_timeout <= 1'b1;
              rsp_funct   <= fpu_funct;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end else begin
            if (fixed_done) begin
              rsp_result  <= fpu_result;
              rsp_timeout <= 1'b0;
              rsp_funct   <= fpu_funct;
              rsp_valid   <= 1'b1;
              state       <= RESP;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: directed corner cases plus random
// transactions, each compared against a latency/result model of the sequencer.
module tb_fpu_sequencer;
  import fpu_pkg::*;

  localparam int ADD_LAT     = 2;
  localparam int MUL_LAT     = 3;
  localparam int DIV_TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_funct;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  fpu_funct;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_result;
  logic        fpu_div_fin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_funct;
  logic        rsp_timeout;

  int checks = 0;
  int errors = 0;

  fpu_sequencer #(
    .ADD_LAT    (ADD_LAT),
    .MUL_LAT    (MUL_LAT),
    .DIV_TIMEOUT(DIV_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct  (req_funct),
    .req_a      (req_a),
    .req_b      (req_b),
    .fpu_funct  (fpu_funct),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_result (fpu_result),
    .fpu_div_fin(fpu_div_fin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_funct  (rsp_funct),
    .rsp_timeout(rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_ready"},   32'(req_ready),   32'd1);
    checkOutput({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    checkOutput({tag, "_rsp_result"},  rsp_result,       32'd0);
    checkOutput({tag, "_rsp_funct"},   32'(rsp_funct),   32'd0);
    checkOutput({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    checkOutput({tag, "_fpu_funct"},   32'(fpu_funct),   32'd0);
    checkOutput({tag, "_fpu_a"},       fpu_a,            32'd0);
    checkOutput({tag, "_fpu_b"},       fpu_b,            32'd0);
  endtask

  // One complete transaction, entered and left #1 after a rising edge with the DUT idle.
  // fin_cycle is the EXEC cycle index (0 = first) on which the divider raises finish.
  task automatic applyStimulus(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input int fin_cycle, input bit fin_early,
                               input int hold, input bit keep_valid);
    int          cap;
    logic [31:0] exp_res;
    logic        exp_to;
    exp_res = res;
    exp_to  = 1'b0;
    if (f == FPU_MUL) cap = MUL_LAT + 1;
    else if (f == FPU_DIV) begin
      if (fin_cycle >= 1 && fin_cycle <= DIV_TIMEOUT) cap = fin_cycle + 1;
      else begin
        cap     = DIV_TIMEOUT + 1;
        exp_res = FPU_QNAN;
        exp_to  = 1'b1;
      end
    end else cap = ADD_LAT + 1;

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_funct   = f;
    req_a       = a;
    req_b       = b;
    rsp_ready   = 1'b0;
    fpu_result  = ~res;
    fpu_div_fin = 1'b0;
    @(posedge clk); #1;
    req_valid = keep_valid;
    req_a     = $urandom;
    req_b     = $urandom;
    checkOutput("fpu_a_launch", fpu_a, a);

    for (int k = 1; k <= cap; k++) begin
      fpu_result  = (k == cap) ? res : (~res ^ 32'(k));
      fpu_div_fin = ((f == FPU_DIV) && (k - 1 == fin_cycle)) || (fin_early && k == 1);
      @(posedge clk); #1;
      if (k < cap) checkOutput("rsp_valid_early", 32'(rsp_valid), 32'd0);
    end
    fpu_div_fin = 1'b0;

    checkOutput("rsp_valid",   32'(rsp_valid),   32'd1);
    checkOutput("rsp_result",  rsp_result,       exp_res);
    checkOutput("rsp_funct",   32'(rsp_funct),   32'(f));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
    checkOutput("fpu_funct_held", 32'(fpu_funct), 32'(f));
    checkOutput("fpu_b_held",  fpu_b, b);

    for (int h = 0; h < hold; h++) begin
      fpu_result  = $urandom;
      fpu_div_fin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkOutput("bp_rsp_valid",  32'(rsp_valid),  32'd1);
      checkOutput("bp_rsp_result", rsp_result,      exp_res);
      checkOutput("bp_req_ready",  32'(req_ready),  32'd0);
    end
    fpu_div_fin = 1'b0;

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    checkOutput("req_ready_back", 32'(req_ready), 32'd1);
    checkOutput("fpu_a_stable",   fpu_a, a);
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_funct   = 2'd0;
    req_a       = 32'd0;
    req_b       = 32'd0;
    fpu_result  = 32'd0;
    fpu_div_fin = 1'b0;
    rsp_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkResetValues("reset");

    // Add: 1.0 + 2.0 = 3.0
    applyStimulus(FPU_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, -1, 1'b0, 0, 1'b0);
    // Divide 6.0 / 2.0, finish on EXEC cycle 5, stale finish high in the first cycle
    applyStimulus(FPU_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5, 1'b1, 0, 1'b0);
    // Divide that never finishes
    applyStimulus(FPU_DIV, 32'h40C0_0000, 32'h0000_0000, 32'h1234_5678, 1000, 1'b0, 0, 1'b0);
    // Finish on the same cycle the timeout is reached
    applyStimulus(FPU_DIV, 32'h4120_0000, 32'h4000_0000, 32'h40A0_0000, DIV_TIMEOUT, 1'b0, 0, 1'b0);
    // Backpressure: ten cycles of rsp_ready low while a new request waits
    applyStimulus(FPU_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, -1, 1'b0, 10, 1'b1);
    applyStimulus(FPU_MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, -1, 1'b1, 2, 1'b0);

    // Reset in the middle of a multiply
    req_valid = 1'b1;
    req_funct = FPU_MUL;
    req_a     = 32'hDEAD_BEEF;
    req_b     = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < MUL_LAT + 3; i++) begin
      @(posedge clk); #1;
      checkOutput("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(FPU_MUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, -1, 1'b0, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    int'($urandom_range(1, 70)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
